wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter that owns the register file's single write port (we3/a3/wd3). It merges single-cycle ALU results with variable-latency load responses, buffering loads in a small FIFO. It also maintains a pending-load scoreboard so the issue stage can stall on unresolved load destinations. It sits between the execute/memory stages and the register file.

## Interface

**Parameters**
- DEPTH, 4: load FIFO entries; must be a power of 2, minimum 2.

**Ports**
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_ready  out  1  ALU result accepted; equals !fifo_full (combinational).
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ld_valid  in  1  load response present.
- ld_ready  out  1  load response accepted; equals !fifo_full (combinational).
- ld_rd  in  5  load destination register.
- ld_data  in  32  load data.
- issue_valid  in  1  a load is being issued this cycle.
- issue_rd  in  5  destination register of the issued load.
- busy  out  32  bit i set means a load to xi is pending; bit 0 is always 0.
- fifo_count  out  $clog2(DEPTH)+1  number of occupied FIFO entries.
- we3  out  1  register file write enable (registered).
- a3  out  5  register file write address (registered).
- wd3  out  32  register file write data (registered).

## Operation

- **Acceptance.** A transfer happens when valid && ready. ld_valid and ld_rd/ld_data must hold until accepted. The ALU side must hold likewise while alu_ready=0.
- **Load path.** An accepted load pushes {ld_rd, ld_data} into the FIFO tail.
- **Arbitration, evaluated each cycle:**
  - Accepted ALU result present: ALU is selected.
  - No accepted ALU result and FIFO non-empty: FIFO head is selected and popped.
  - Otherwise: nothing is selected.
- **Starvation relief.** A full FIFO forces alu_ready=0, so the FIFO head wins that cycle.
- **x0 handling.** A selected entry with rd==0 is consumed, but we3 stays 0 next cycle (write dropped).
- **Output register.** At each edge, we3 <= (selected && rd!=0); a3/wd3 <= selected rd/data. When nothing is selected, a3/wd3 hold their previous values.
- **Scoreboard:**
  - issue_valid with issue_rd!=0 sets busy[issue_rd] at the next edge.
  - Popping a FIFO entry clears busy[rd] at the same edge that registers we3.
  - Simultaneous set and clear of the same bit: set wins.
  - Issuing to an already-busy register leaves the bit set; it clears at the first completion.
  - ALU writes never modify busy.
- **Push and pop in the same cycle.** Occupancy is unchanged; this is legal when full only if a pop occurs. With ld_ready=!full, a full FIFO never pushes.

## Timing

- **Reset values:** we3=0, a3=0, wd3=0, busy=0, fifo_count=0, FIFO empty. alu_ready and ld_ready are 1 out of reset.
- **Reset mid-operation** discards all FIFO contents and pending busy bits. Any in-flight output write is cancelled because we3 forces to 0 asynchronously.
- **ALU latency:** alu_valid && alu_ready at cycle t gives we3=1 at cycle t+1.
- **Load latency:** accepted into an empty FIFO at t, with no ALU valid at t+1, gives we3=1 at t+2. busy clears at that same t+2 edge.
- **Throughput:** one register-file write per cycle.
- **Pointers:** $clog2(DEPTH)-bit pointers that wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- **Readiness:** ready outputs depend only on registered state; there is no combinational path from any valid to any ready.

## Structure

- Package wb_pkg holds:
  - typedef wb_entry_t as a packed struct {logic [4:0] rd; logic [31:0] data}.
  - localparam REG_ZERO = 5'd0.
- Sub-module wb_fifo is a parameterised synchronous FIFO of wb_entry_t. It has push/pop/full/empty/count, asynchronous active-low reset, and no read latency (the head is always visible).
- wb_arbiter contains the selection logic, the output register, and the busy scoreboard.

## Test plan

- **ALU only:** alu_valid with rd=5, data=0xDEADBEEF at t -> we3=1, a3=5, wd3=0xDEADBEEF at t+1; we3=0 at t+2.
- **Load with scoreboard:** issue_rd=7 at t0 -> busy[7]=1 at t0+1. Load rd=7, data=0x12345678 accepted at t1 with no ALU traffic -> we3=1, a3=7 at t1+2, and busy[7]=0 on the same edge.
- **Contention:** ALU valid every cycle while 4 loads (rd 1..4) arrive:
  - FIFO fills and fifo_count reaches 4.
  - alu_ready=0 and ld_ready=0 together.
  - Loads drain in FIFO order, rd 1, 2, 3, 4.
  - No result is lost or duplicated.
- **x0 writes:** ALU rd=0 and load rd=0 are both accepted, and neither produces we3=1. Issue with issue_rd=0 leaves busy=0.
- **Set wins:** issue_rd=9 in the same cycle that the FIFO head with rd=9 pops -> busy[9]=1 afterwards.
- **Reset mid-operation:** reset_n pulsed low with 3 FIFO entries and busy=0x000000F0 -> all outputs return to reset values immediately, and no stale write appears after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: the FIFO entry and a register-mask helper.
package wb_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic [31:0] rd_mask(input logic [4:0] rd);
    rd_mask = 32'd1 << rd;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; the head is visible with no read latency.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  wb_entry_t              wdata,
  input  logic                   pop,
  output wb_entry_t              rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ZERO = (AW+1)'(1'b0);

  wb_entry_t     mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == CNT_ZERO);
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Entry storage, cleared on reset so a stale head never leaks out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy is tracked separately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= AW'(1'b0);
      rd_ptr_r <= AW'(1'b0);
      count_r  <= CNT_ZERO;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Owns the register-file write port: ALU results take priority, loads queue in a FIFO,
// and a scoreboard tracks which load destinations are still outstanding.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [4:0]             alu_rd,
  input  logic [31:0]            alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [4:0]             ld_rd,
  input  logic [31:0]            ld_data,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rd,
  output logic [31:0]            busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   we3,
  output logic [4:0]             a3,
  output logic [31:0]            wd3
);

  logic      fifo_full_s;
  logic      fifo_empty_s;
  wb_entry_t head_s;
  wb_entry_t ld_entry_s;
  logic      alu_acc_s;
  logic      ld_acc_s;
  logic      pop_s;
  logic      sel_valid_s;
  wb_entry_t sel_entry_s;
  logic [31:0] set_mask_s;
  logic [31:0] clr_mask_s;
  logic [31:0] busy_next_s;

  logic        we3_r;
  logic [4:0]  a3_r;
  logic [31:0] wd3_r;
  logic [31:0] busy_r;

  // A full FIFO blocks the ALU so the queued loads cannot starve.
  assign alu_ready  = !fifo_full_s;
  assign ld_ready   = !fifo_full_s;
  assign alu_acc_s  = alu_valid && alu_ready;
  assign ld_acc_s   = ld_valid && ld_ready;
  assign ld_entry_s = '{rd: ld_rd, data: ld_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (ld_acc_s),
    .wdata   (ld_entry_s),
    .pop     (pop_s),
    .rdata   (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count)
  );

  // Write-port selection and scoreboard masks.
  always_comb begin
    pop_s       = 1'b0;
    sel_valid_s = 1'b0;
    sel_entry_s = '0;
    clr_mask_s  = 32'd0;
    set_mask_s  = 32'd0;
    if (alu_acc_s) begin
      sel_valid_s = 1'b1;
      sel_entry_s = '{rd: alu_rd, data: alu_data};
    end else if (!fifo_empty_s) begin
      pop_s       = 1'b1;
      sel_valid_s = 1'b1;
      sel_entry_s = head_s;
      clr_mask_s  = rd_mask(head_s.rd);
    end else begin
      sel_valid_s = 1'b0;
    end
    if (issue_valid && (issue_rd != REG_ZERO)) begin
      set_mask_s = rd_mask(issue_rd);
    end else begin
      set_mask_s = 32'd0;
    end
    busy_next_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
  end

  // Output register; a3/wd3 hold when no entry is selected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we3_r <= 1'b0;
      a3_r  <= 5'd0;
      wd3_r <= 32'd0;
    end else begin
      we3_r <= sel_valid_s && (sel_entry_s.rd != REG_ZERO);
      if (sel_valid_s) begin
        a3_r  <= sel_entry_s.rd;
        wd3_r <= sel_entry_s.data;
      end
    end
  end

  // Pending-load scoreboard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign we3  = we3_r;
  assign a3   = a3_r;
  assign wd3  = wd3_r;
  assign busy = busy_r;

endmodule
